fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  First pipeline stage: owns the PC, issues instruction-memory reads, and hands {PC, instruction} to decode_stage.
//  Drives decode's prev_done and obeys its stall_prev; consumes decode's control_flow_affected / jump_target redirect.
//  Supports at most one outstanding memory read and one buffered instruction.
// PARAMETERS
//  ADDR_WIDTH         32            PC / memory address width
//  INSTRUCTION_WIDTH  32            instruction word width
//  RESET_VECTOR       32'h0000_0000 first PC fetched after reset
// PORTS
//  clk                        in   1    single clock; all flops on posedge
//  rst_n                      in   1    reset, asynchronous, active-low
//  next_stall                 in   1    from decode stall_prev; 1 = decode will not accept
//  done_next                  out  1    to decode prev_done; 1 = buffered instruction offered
//  control_flow_affected      in   1    decode requests redirect (level)
//  jump_target                in   AW   redirect address
//  jump_target_valid          in   1    jump_target is resolved
//  imem_req_valid             out  1    read request
//  imem_req_ready             in   1    memory accepts request
//  imem_req_addr              out  AW   read address (= pc)
//  imem_resp_valid            in   1    read data returned (>=1 cycle after accept)
//  imem_resp_data             in   IW   read data
//  imem_resp_error            in   1    access fault on this response
//  program_count_out          out  AW   PC of buffered instruction
//  program_count_valid_out    out  1    PC field meaningful
//  instruction_data_out       out  IW   buffered instruction
//  instruction_data_valid_out out  1    0 = fault/misaligned; decode treats as illegal
// BEHAVIOUR
//  Reset (rst_n=0, async): pc=RESET_VECTOR; state=IDLE; buffer empty; done_next=0, imem_req_valid=0,
//   program_count_valid_out=0, instruction_data_valid_out=0, data outputs 0.
//  transfer = done_next && !next_stall; accept = imem_req_valid && imem_req_ready.
//  redirect_hold = control_flow_affected; redirect_load = control_flow_affected && jump_target_valid.
//  States: IDLE (none outstanding), WAIT (outstanding, keep), DROP (outstanding, discard).
//  Request issue: imem_req_valid = (state==IDLE) && !redirect_hold && pc[1:0]==0 && (buffer empty || transfer).
//   On accept: pc <= pc+4 (mod 2^AW, wraps to 0); IDLE->WAIT.
//  Response: WAIT & imem_resp_valid -> IDLE; buffer <= {pc_of_req, resp_data}, valid_out=!resp_error.
//   DROP & imem_resp_valid -> IDLE; data discarded, buffer untouched. imem_resp_valid in IDLE ignored.
//  Latency: request accepted cycle N, response cycle N+k -> done_next=1 from cycle N+k+1. Back-to-back
//   issue allowed in the response cycle only if buffer empties (transfer) that cycle; else 1 bubble.
//  done_next = buffer full && !redirect_hold. Buffer clears on transfer; buffer refilled same cycle allowed.
//  Redirect: any cycle redirect_hold=1 -> no issue, done_next=0, buffer squashed (cleared),
//   WAIT->DROP. If redirect_load also: pc <= jump_target (repeated each cycle while held; last value wins).
//   redirect_hold without jump_target_valid: stall only, pc unchanged.
//  Misaligned pc (pc[1:0]!=0) in IDLE, no redirect, buffer free: no memory request; buffer <= {pc, X},
//   program_count_valid_out=1, instruction_data_valid_out=0; pc unchanged (decode raises exception/redirect).
//  Simultaneous: redirect + imem_resp_valid in WAIT -> response dropped, state IDLE. transfer + response
//   same cycle -> old entry leaves, new entry loads. redirect overrides transfer (done_next already 0).
//  Outputs are registered from buffer; stable while done_next=1 && next_stall=1.
//  rst_n asserted mid-transaction: state lost immediately; memory shares rst_n and drops in-flight read.
// TESTING
//  1 Reset release, mem latency 1, next_stall=0 -> reads 0x0,0x4,0x8; decode sees PCs 0x0,0x4,0x8 one per 2 cycles.
//  2 next_stall=1 for 5 cycles with buffer full -> done_next held, outputs stable, no second request issued.
//  3 Redirect to 0x100 while read of 0x8 outstanding -> 0x8 data dropped, next decoded PC 0x100, then 0x104.
//  4 control_flow_affected=1, jump_target_valid=0 for 3 cycles then valid 0x40 -> no requests until target, next PC 0x40.
//  5 imem_resp_error=1 at PC 0x10 -> done_next=1, PC 0x10, instruction_data_valid_out=0; jump to 0x42 -> no request, valid_out=0.
//  6 pc=0xFFFF_FFFC fetched -> next request addr 0x0000_0000; rst_n pulse mid-WAIT -> outputs cleared, refetch 0x0.

Source files
------------

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// fetch_stage_if : instruction-memory request/response bus     rev 1.0
// ============================================================================
interface fetch_stage_if #(
   parameter int ADDR_WIDTH        = 32,
   parameter int INSTRUCTION_WIDTH = 32
);
   logic                         req_valid;
   logic                         req_ready;
   logic [ADDR_WIDTH-1:0]        req_addr;
   logic                         resp_valid;
   logic [INSTRUCTION_WIDTH-1:0] resp_data;
   logic                         resp_error;

   modport master (
      output req_valid, req_addr,
      input  req_ready, resp_valid, resp_data, resp_error
   );

   modport slave (
      input  req_valid, req_addr,
      output req_ready, resp_valid, resp_data, resp_error
   );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage : PC owner, single-outstanding imem reader, one-entry buffer to decode   rev 1.0
// ============================================================================
module fetch_stage #(
   parameter int                    ADDR_WIDTH        = 32,
   parameter int                    INSTRUCTION_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR      = '0
) (
   input  wire logic                         clk,
   input  wire logic                         rst_n,
   fetch_stage_if.master                     imem,
   input  wire logic                         next_stall_i,
   output logic                              done_next_o,
   input  wire logic                         control_flow_affected_i,
   input  wire logic [ADDR_WIDTH-1:0]        jump_target_i,
   input  wire logic                         jump_target_valid_i,
   output logic [ADDR_WIDTH-1:0]             program_count_o,
   output logic                              program_count_valid_o,
   output logic [INSTRUCTION_WIDTH-1:0]      instruction_data_o,
   output logic                              instruction_data_valid_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t                       state_q;
   logic [ADDR_WIDTH-1:0]        pc_q;
   logic [ADDR_WIDTH-1:0]        req_pc_q;
   logic                         buf_full_q;
   logic [ADDR_WIDTH-1:0]        buf_pc_q;
   logic [INSTRUCTION_WIDTH-1:0] buf_data_q;
   logic                         buf_dv_q;

   logic w_hold;
   logic w_load;
   logic w_transfer;
   logic w_buf_free;
   logic w_aligned;
   logic w_accept;

   assign w_hold      = control_flow_affected_i;
   assign w_load      = w_hold && jump_target_valid_i;
   assign done_next_o = rst_n && buf_full_q && !w_hold;
   assign w_transfer  = done_next_o && !next_stall_i;
   assign w_buf_free  = !buf_full_q || w_transfer;
   assign w_aligned   = (pc_q[1:0] == 2'b00);

   // Only issue when the buffer is guaranteed a slot for the response.
   assign imem.req_valid = rst_n && (state_q == S_IDLE) && !w_hold && w_aligned && w_buf_free;
   assign imem.req_addr  = pc_q;
   assign w_accept       = imem.req_valid && imem.req_ready;

   assign program_count_o          = buf_pc_q;
   assign program_count_valid_o    = buf_full_q;
   assign instruction_data_o       = buf_data_q;
   assign instruction_data_valid_o = buf_dv_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_VECTOR;
         req_pc_q   <= '0;
         buf_full_q <= 1'b0;
         buf_pc_q   <= '0;
         buf_data_q <= '0;
         buf_dv_q   <= 1'b0;
      end else if (w_hold) begin
         // Redirect squashes the buffer and poisons any in-flight read.
         buf_full_q <= 1'b0;
         buf_dv_q   <= 1'b0;
         if (w_load) begin
            pc_q <= jump_target_i;
         end
         if (state_q != S_IDLE) begin
            state_q <= imem.resp_valid ? S_IDLE : S_DROP;
         end
      end else begin
         if (w_transfer) begin
            buf_full_q <= 1'b0;
            buf_dv_q   <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (w_accept) begin
                  pc_q     <= pc_q + ADDR_WIDTH'(4);
                  req_pc_q <= pc_q;
                  state_q  <= S_WAIT;
               end else if (!w_aligned && w_buf_free) begin
                  buf_full_q <= 1'b1;
                  buf_pc_q   <= pc_q;
                  buf_data_q <= '0;
                  buf_dv_q   <= 1'b0;
               end
            end
            S_WAIT: begin
               if (imem.resp_valid) begin
                  state_q    <= S_IDLE;
                  buf_full_q <= 1'b1;
                  buf_pc_q   <= req_pc_q;
                  buf_data_q <= imem.resp_data;
                  buf_dv_q   <= !imem.resp_error;
               end
            end
            S_DROP: begin
               if (imem.resp_valid) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// tb_fetch_stage : directed bench with queue-based reference model     rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_stage;
   localparam int AW = 32;
   localparam int IW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          next_stall = 1'b0;
   logic          cfa = 1'b0;
   logic          jtv = 1'b0;
   logic [AW-1:0] jt = '0;
   logic          done_next;
   logic [AW-1:0] pc_out;
   logic          pcv;
   logic [IW-1:0] data_out;
   logic          dv;

   fetch_stage_if #(.ADDR_WIDTH(AW), .INSTRUCTION_WIDTH(IW)) ifc ();

   fetch_stage #(.ADDR_WIDTH(AW), .INSTRUCTION_WIDTH(IW), .RESET_VECTOR(32'h0)) dut (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .imem                     (ifc),
      .next_stall_i             (next_stall),
      .done_next_o              (done_next),
      .control_flow_affected_i  (cfa),
      .jump_target_i            (jt),
      .jump_target_valid_i      (jtv),
      .program_count_o          (pc_out),
      .program_count_valid_o    (pcv),
      .instruction_data_o       (data_out),
      .instruction_data_valid_o (dv)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   typedef struct { logic [31:0] pc; logic [31:0] data; logic dv; } ent_t;
   typedef struct { logic [31:0] pc; logic [31:0] data; logic dv; int cyc; } log_t;

   ent_t        mbuf[$];
   log_t        tlog[$];
   logic [31:0] acc_q[$];
   int          acc_count = 0;
   int          mem_lat   = 1;
   logic [31:0] err_addr  = 32'h10;

   logic [31:0] m_pc = '0, m_raddr = '0;
   bit          m_infl = 0, m_disc = 0, m_xfer, m_req;

   function automatic logic [31:0] mem_data(logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit exp_done();
      return rst_n && (mbuf.size() == 1) && !cfa;
   endfunction

   function automatic bit exp_req();
      return rst_n && !m_infl && !cfa && (m_pc[1:0] == 2'b00) &&
             ((mbuf.size() == 0) || (exp_done() && !next_stall));
   endfunction

   function automatic logic [31:0] log_pc(int i);
      return (tlog.size() > i) ? tlog[i].pc : 32'hxxxx_xxxx;
   endfunction

   function automatic logic [31:0] acc_at(int i);
      return (acc_q.size() > i) ? acc_q[i] : 32'hxxxx_xxxx;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Memory: single outstanding read, fixed latency, drops everything on reset.
   initial begin : mem
      int cnt;
      logic [31:0] paddr;
      cnt = 0;
      paddr = '0;
      ifc.resp_valid = 1'b0;
      ifc.resp_data  = '0;
      ifc.resp_error = 1'b0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            cnt = 0;
            ifc.resp_valid = 1'b0;
         end else begin
            if (ifc.req_valid && ifc.req_ready) begin
               cnt   = mem_lat;
               paddr = ifc.req_addr;
               acc_q.push_back(ifc.req_addr);
               acc_count++;
            end
            #1;
            ifc.resp_valid = 1'b0;
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  ifc.resp_valid = 1'b1;
                  ifc.resp_data  = mem_data(paddr);
                  ifc.resp_error = (paddr == err_addr);
               end
            end
         end
      end
   end

   // Reference model: pc, at most one read in flight (kept or discarded), one-entry buffer.
   initial begin : model
      ent_t e;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_pc = '0; m_infl = 0; m_disc = 0;
            mbuf.delete();
         end else begin
            m_xfer = exp_done() && !next_stall;
            m_req  = exp_req();
            if (cfa) begin
               mbuf.delete();
               if (jtv) m_pc = jt;
               if (m_infl) begin
                  if (ifc.resp_valid) m_infl = 0;
                  else m_disc = 1;
               end
            end else begin
               if (m_xfer) mbuf.delete(0);
               if (!m_infl) begin
                  if (m_req && ifc.req_ready) begin
                     m_raddr = m_pc;
                     m_pc    = m_pc + 32'd4;
                     m_infl  = 1;
                     m_disc  = 0;
                  end else if (m_pc[1:0] != 2'b00 && mbuf.size() == 0) begin
                     e.pc = m_pc; e.data = '0; e.dv = 1'b0;
                     mbuf.push_back(e);
                  end
               end else if (ifc.resp_valid) begin
                  m_infl = 0;
                  if (!m_disc) begin
                     e.pc = m_raddr; e.data = ifc.resp_data; e.dv = !ifc.resp_error;
                     mbuf.push_back(e);
                  end
               end
            end
         end
      end
   end

   // Per-cycle compare against the model; also records each transfer to decode.
   initial begin : compare
      log_t l;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_done_next", done_next, 0);
            chk("rst_req_valid", ifc.req_valid, 0);
            chk("rst_pc_valid", pcv, 0);
            chk("rst_data_valid", dv, 0);
            chk("rst_pc_out", pc_out, 0);
            chk("rst_data_out", data_out, 0);
         end else begin
            chk("done_next", done_next, exp_done());
            chk("req_valid", ifc.req_valid, exp_req());
            if (exp_req()) chk("req_addr", ifc.req_addr, m_pc);
            chk("pc_valid", pcv, mbuf.size() == 1);
            if (exp_done()) begin
               chk("out_pc", pc_out, mbuf[0].pc);
               chk("data_valid", dv, mbuf[0].dv);
               if (mbuf[0].dv) chk("out_data", data_out, mbuf[0].data);
            end
            if (done_next && !next_stall) begin
               l.pc = pc_out; l.data = data_out; l.dv = dv; l.cyc = cyc;
               tlog.push_back(l);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_log(int n, int budget, string name);
      int i = 0;
      while (tlog.size() < n && i < budget) begin
         tick();
         i++;
      end
      if (tlog.size() < n) begin
         n_cmp++; n_err++;
         $display("FAIL %s_timeout: got %0d transfers required %0d", name, tlog.size(), n);
      end
   endtask

   task automatic wait_acc(int n, int budget, string name);
      int i = 0;
      while (acc_q.size() < n && i < budget) begin
         tick();
         i++;
      end
      if (acc_q.size() < n) begin
         n_cmp++; n_err++;
         $display("FAIL %s_timeout: got %0d requests required %0d", name, acc_q.size(), n);
      end
   endtask

   task automatic redirect(logic [31:0] tgt);
      cfa = 1'b1; jt = tgt; jtv = 1'b1;
      tick();
      cfa = 1'b0; jtv = 1'b0;
   endtask

   initial begin : stim
      int a0;
      int i;
      ifc.req_ready = 1'b1;

      // 1: reset release, latency 1, free-running decode
      rst_n = 1'b0;
      repeat (3) tick();
      chk("t1_rst_req", ifc.req_valid, 0);
      tlog.delete();
      rst_n = 1'b1;
      wait_log(3, 20, "t1");
      chk("t1_pc0", log_pc(0), 32'h0);
      chk("t1_pc1", log_pc(1), 32'h4);
      chk("t1_pc2", log_pc(2), 32'h8);
      if (tlog.size() >= 3) begin
         chk("t1_data1", tlog[1].data, 32'hDEAD_BEEB);
         chk("t1_gap01", tlog[1].cyc - tlog[0].cyc, 2);
         chk("t1_gap12", tlog[2].cyc - tlog[1].cyc, 2);
      end

      // 2: decode stalls with buffer full
      next_stall = 1'b1;
      tick();
      a0 = acc_count;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t2_done", done_next, 1);
         chk("t2_pc", pc_out, 32'hC);
         chk("t2_data", data_out, 32'hDEAD_BEE3);
         chk("t2_req", ifc.req_valid, 0);
         tick();
      end
      chk("t2_no_issue", acc_count - a0, 0);

      // 3: redirect while read of 0x8 outstanding (latency 3)
      rst_n = 1'b0;
      tick(); tick();
      mem_lat = 3;
      next_stall = 1'b0;
      acc_q.delete();
      rst_n = 1'b1;
      wait_acc(3, 40, "t3_acc");
      chk("t3_acc8", acc_at(2), 32'h8);
      tlog.delete();
      redirect(32'h100);
      wait_log(2, 40, "t3");
      chk("t3_pc0", log_pc(0), 32'h100);
      chk("t3_pc1", log_pc(1), 32'h104);
      if (tlog.size() >= 1) chk("t3_data0", tlog[0].data, 32'hDEAD_BFEF);

      // 4: redirect held without a resolved target
      tlog.delete();
      cfa = 1'b1; jtv = 1'b0;
      a0 = acc_count;
      repeat (3) tick();
      jt = 32'h40; jtv = 1'b1;
      tick();
      cfa = 1'b0; jtv = 1'b0;
      chk("t4_no_issue", acc_count - a0, 0);
      wait_log(1, 40, "t4");
      chk("t4_pc0", log_pc(0), 32'h40);
      if (tlog.size() >= 1) chk("t4_data0", tlog[0].data, 32'hDEAD_BEAF);

      // 5: access fault at 0x10, then misaligned jump to 0x42
      next_stall = 1'b1;
      redirect(32'h10);
      i = 0;
      while (!done_next && i < 40) begin
         tick();
         i++;
      end
      chk("t5_done", done_next, 1);
      chk("t5_pc", pc_out, 32'h10);
      chk("t5_pcv", pcv, 1);
      chk("t5_dv", dv, 0);
      next_stall = 1'b0;
      tick();
      next_stall = 1'b1;
      a0 = acc_count;
      redirect(32'h42);
      repeat (6) tick();
      chk("t5_mis_no_issue", acc_count - a0, 0);
      chk("t5_mis_done", done_next, 1);
      chk("t5_mis_pc", pc_out, 32'h42);
      chk("t5_mis_pcv", pcv, 1);
      chk("t5_mis_dv", dv, 0);

      // 6: pc wrap, then async reset while a read is outstanding
      next_stall = 1'b0;
      mem_lat = 1;
      acc_q.delete();
      redirect(32'hFFFF_FFFC);
      wait_acc(2, 20, "t6_wrap");
      chk("t6_acc_top", acc_at(0), 32'hFFFF_FFFC);
      chk("t6_acc_wrap", acc_at(1), 32'h0);
      mem_lat = 3;
      acc_q.delete();
      wait_acc(1, 20, "t6_pre");
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_done", done_next, 0);
      chk("t6_rst_req", ifc.req_valid, 0);
      chk("t6_rst_pcv", pcv, 0);
      chk("t6_rst_dv", dv, 0);
      chk("t6_rst_pc", pc_out, 0);
      chk("t6_rst_data", data_out, 0);
      tick(); tick();
      acc_q.delete();
      tlog.delete();
      rst_n = 1'b1;
      wait_log(1, 20, "t6_refetch");
      chk("t6_refetch_acc", acc_at(0), 32'h0);
      chk("t6_refetch_pc", log_pc(0), 32'h0);
      if (tlog.size() >= 1) chk("t6_refetch_data", tlog[0].data, 32'hDEAD_BEEF);

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
